// File: rtl/keypad_if.sv
// keypad_if: key code FIFO head with valid/ready handshake.
interface keypad_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  modport master (output key_code, key_valid, input key_ready);
  modport slave (input key_code, key_valid, output key_ready);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad row scanner with per-scan debounce and a 4-entry key FIFO.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int SCAN_CNT       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 100
) (
  input  logic       CLK_50M,
  input  logic       Rst_n,
  output logic [3:0] KEY_ROW,
  input  logic [3:0] KEY_COL,
  keypad_if.master   key,
  output logic       key_held,
  output logic       overflow
);
  localparam int DW = $clog2(SCAN_CNT);
  typedef enum logic [1:0] {RELEASED, PRESS_DB, PRESSED, RELEASE_DB} state_t;
  state_t state, state_n;
  logic [3:0] col_s1, col_s2;
  logic [DW-1:0] dwell;
  logic [1:0] row;
  logic [15:0] snap;
  logic scan_done, last;
  logic [4:0] ones;
  logic [3:0] idx, cnt, cnt_n, cand, cand_n;
  logic single, multi, same, push, push_all, pop, full, wr;
  logic [3:0] mem [4];
  logic [1:0] wp, rp;
  logic [2:0] count;
  assign last = dwell == DW'(SCAN_CNT - 1);
  assign KEY_ROW = ~(4'b0001 << row);
  always_ff @(posedge CLK_50M or negedge Rst_n)
    if (!Rst_n) begin
      col_s1 <= '1;
      col_s2 <= '1;
      dwell <= '0;
      row <= '0;
      snap <= '0;
      scan_done <= 1'b0;
    end else begin
      col_s1 <= KEY_COL;
      col_s2 <= col_s1;
      dwell <= last ? '0 : dwell + 1'b1;
      row <= last ? row + 2'd1 : row;
      if (last) snap[4*row +: 4] <= ~col_s2;
      scan_done <= last && row == 2'd3;
    end
  // Bit index 4*row+col is already the {row, col} key code.
  always_comb begin
    ones = '0;
    idx = '0;
    for (int i = 0; i < 16; i++)
      if (snap[i]) begin
        ones = ones + 5'd1;
        idx = 4'(i);
      end
  end
  assign single = ones == 5'd1;
  assign multi = ones > 5'd1;
  assign same = single && idx == cand;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    cand_n = cand;
    push = 1'b0;
    if (scan_done)
      case (state)
        RELEASED: if (single) begin
          cand_n = idx;
          cnt_n = 4'd1;
          state_n = PRESS_DB;
          if (DEBOUNCE_SCANS == 1) begin
            push = 1'b1;
            cnt_n = '0;
            state_n = PRESSED;
          end
        end
        PRESS_DB: if (same) begin
          cnt_n = cnt + 4'd1;
          if (cnt_n == 4'(DEBOUNCE_SCANS)) begin
            push = 1'b1;
            cnt_n = '0;
            state_n = PRESSED;
          end
        end else if (single) begin
          cand_n = idx;
          cnt_n = 4'd1;
        end else begin
          cnt_n = '0;
          state_n = RELEASED;
        end
        PRESSED: if (same || multi) cnt_n = '0;
        else begin
          cnt_n = DEBOUNCE_SCANS == 1 ? 4'd0 : 4'd1;
          state_n = DEBOUNCE_SCANS == 1 ? RELEASED : RELEASE_DB;
        end
        RELEASE_DB: if (same) begin
          cnt_n = '0;
          state_n = PRESSED;
        end else if (!multi) begin
          cnt_n = cnt + 4'd1;
          if (cnt_n == 4'(DEBOUNCE_SCANS)) begin
            cnt_n = '0;
            state_n = RELEASED;
          end
        end
        default: state_n = RELEASED;
      endcase
  end
  always_ff @(posedge CLK_50M or negedge Rst_n)
    if (!Rst_n) begin
      state <= RELEASED;
      cnt <= '0;
      cand <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      cand <= cand_n;
    end
  assign key_held = state == PRESSED || state == RELEASE_DB;
`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  logic [RW-1:0] rep;
  logic rep_hit;
  assign rep_hit = scan_done && state == PRESSED && same && rep == RW'(REPEAT_SCANS - 1);
  // Returning from RELEASE_DB keeps the count so bounces do not delay repeats.
  always_ff @(posedge CLK_50M or negedge Rst_n)
    if (!Rst_n) rep <= '0;
    else if (scan_done && state == PRESSED && same) rep <= rep_hit ? '0 : rep + 1'b1;
    else if (state_n == PRESSED && state != PRESSED && state != RELEASE_DB) rep <= '0;
  assign push_all = push | rep_hit;
`else
  assign push_all = push;
`endif
  assign pop = key.key_valid && key.key_ready;
  assign full = count == 3'd4;
  assign wr = push_all && (!full || pop);
  always_ff @(posedge CLK_50M or negedge Rst_n)
    if (!Rst_n) begin
      mem <= '{default: '0};
      wp <= '0;
      rp <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) mem[wp] <= idx;
      wp <= wp + {1'b0, wr};
      rp <= rp + {1'b0, pop};
      count <= count + {2'b0, wr} - {2'b0, pop};
      overflow <= push_all && full && !pop;
    end
  assign key.key_code = mem[rp];
  assign key.key_valid = count != 3'd0;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized scoreboard bench for keypad_scanner against a scan-level key model.
module tb_keypad_scanner;
  localparam int SC = 8, DB = 2, RS = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] key_row, key_col;
  logic key_held, overflow;
  logic [15:0] keys = '0;
  int checks = 0, failures = 0;
  int rdy_mode = 1;
  logic [3:0] exp_q[$];
  int exp_ovf = 0, got_ovf = 0;
  bit down = 0;
  int run = 0, gone = 0, rep = 0;
  logic [3:0] cand = '0;
  keypad_if kif();
  keypad_scanner #(.SCAN_CNT(SC), .DEBOUNCE_SCANS(DB), .REPEAT_SCANS(RS)) dut (
    .CLK_50M(clk), .Rst_n(rst_n), .KEY_ROW(key_row), .KEY_COL(key_col),
    .key(kif), .key_held(key_held), .overflow(overflow));
  always #5 clk = ~clk;
  // Passive switch matrix: a pressed key shorts its driven-low row onto its column.
  always_comb begin
    key_col = '1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!key_row[r] && keys[4*r+c]) key_col[c] = 1'b0;
  end
  initial forever begin
    @(posedge clk);
    #1 kif.key_ready = rdy_mode == 2 ? 1'($urandom % 2) : rdy_mode[0];
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (rst_n) begin
      if (overflow) got_ovf++;
      if (kif.key_valid && kif.key_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pop got=%0h exp=none t=%0t", kif.key_code, $time);
        end else check("pop_code", kif.key_code, exp_q.pop_front());
      end
    end
  task automatic mpush(input logic [3:0] c);
    if (exp_q.size() >= 4) exp_ovf++;
    else exp_q.push_back(c);
  endtask
  // One full scan seen with key set v: count agreeing scans, not FSM states.
  task automatic model_step(input logic [15:0] v);
    int n;
    logic [3:0] c;
    n = $countones(v);
    c = '0;
    for (int i = 0; i < 16; i++) if (v[i]) c = 4'(i);
    if (!down) begin
      if (n == 1 && run > 0 && c == cand) run++;
      else if (n == 1) begin
        cand = c;
        run = 1;
      end else run = 0;
      if (run >= DB) begin
        mpush(cand);
        down = 1;
        gone = 0;
        rep = 0;
      end
    end else if (n == 1 && c == cand) begin
      if (gone == 0) begin
        rep++;
`ifdef KEYPAD_REPEAT_EN
        if (rep == RS) begin
          mpush(cand);
          rep = 0;
        end
`endif
      end
      gone = 0;
    end else if (n < 2) begin
      gone++;
      if (gone >= DB) begin
        down = 0;
        run = 0;
      end
    end
  endtask
  task automatic scan(input logic [15:0] v);
    logic [3:0] prev;
    int t;
    bit seen;
    keys = v;
    prev = key_row;
    t = 0;
    seen = 0;
    while (!seen && t < 200) begin
      @(posedge clk);
      #1 t++;
      seen = prev == 4'b0111 && key_row == 4'b1110;
      prev = key_row;
    end
    if (!seen) check("scan_timeout", 0, 1);
    model_step(v);
    repeat (2) @(posedge clk);
    #1 check("key_held", key_held, down);
  endtask
  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    check("rst_row", key_row, 4'b1110);
    check("rst_valid", kif.key_valid, 0);
    check("rst_code", kif.key_code, 0);
    check("rst_held", key_held, 0);
    check("rst_ovf", overflow, 0);
    down = 0;
    run = 0;
    gone = 0;
    rep = 0;
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    logic [15:0] v;
    int kind, a, b;
    kif.key_ready = 1'b1;
    do_reset();
    // press row 1 / col 2 (code 6) then release
    scan('0);
    repeat (6) scan(16'h0040);
    repeat (3) scan('0);
    drain();
    // press only on alternate scans never debounces
    repeat (3) begin
      scan(16'h0001);
      scan('0);
    end
    // ghosting: keys 0 and 5 together
    repeat (5) scan(16'h0021);
    scan('0);
    drain();
    // fill FIFO with no consumer, fifth press overflows
    rdy_mode = 0;
    for (int k = 1; k <= 5; k++) begin
      v = 16'h0001 << k;
      repeat (2) scan(v);
      repeat (2) scan('0);
    end
    check("full_valid", kif.key_valid, 1);
    check("full_head", kif.key_code, exp_q[0]);
    check("full_ovf", got_ovf, exp_ovf);
    rdy_mode = 1;
    drain();
    repeat (2) @(posedge clk);
    #1 check("empty_valid", kif.key_valid, 0);
    // reset in the middle of debouncing key A
    scan(16'h0400);
    repeat (10) @(posedge clk);
    do_reset();
    scan(16'h0400);
    check("post_rst_valid", kif.key_valid, 0);
    scan(16'h0400);
    repeat (3) scan('0);
    drain();
    // long hold of key F (repeats when enabled)
    repeat (10) scan(16'h8000);
    repeat (3) scan('0);
    drain();
    // random keys, hold lengths and consumer
    rdy_mode = 2;
    for (int i = 0; i < 30; i++) begin
      kind = int'($urandom % 4);
      a = int'($urandom % 16);
      b = (a + 1 + int'($urandom % 15)) % 16;
      v = kind == 0 ? 16'h0 : kind == 3 ? (16'h1 << a) | (16'h1 << b) : 16'h1 << a;
      repeat ($urandom_range(1, 6)) scan(v);
    end
    rdy_mode = 1;
    repeat (3) scan('0);
    drain();
    check("ovf_total", got_ovf, exp_ovf);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
